// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared FSM encoding, master IDs and constants for mem_arb32
package mem_arb_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_ACK   = 2'd2
  } arb_state_t;

  localparam logic       MID_CPU       = 1'b0;
  localparam logic       MID_DBG       = 1'b1;
  localparam logic [3:0] STRB_FULL     = 4'hF;
  localparam int         RAM_WORDS_DEF = 2048;
endpackage

// File: rtl/mem_arb32_if.sv
// rtl/mem_arb32_if.sv - CPU and debug-unit request/response bundle for mem_arb32
interface mem_arb32_if;
  logic        cpu_mem_valid;
  logic [31:0] cpu_mem_addr;
  logic [31:0] cpu_mem_wdata;
  logic [3:0]  cpu_mem_wstrb;
  logic [31:0] cpu_mem_rdata;
  logic        cpu_mem_ready;

  logic [31:0] dbg_adr;
  logic [31:0] dbg_wdata;
  logic        dbg_rw;
  logic        dbg_mem_op;
  logic [31:0] dbg_rdata;
  logic        dbg_mem_rdy;

  modport master (
    output cpu_mem_valid, cpu_mem_addr, cpu_mem_wdata, cpu_mem_wstrb,
    input  cpu_mem_rdata, cpu_mem_ready,
    output dbg_adr, dbg_wdata, dbg_rw, dbg_mem_op,
    input  dbg_rdata, dbg_mem_rdy
  );

  modport slave (
    input  cpu_mem_valid, cpu_mem_addr, cpu_mem_wdata, cpu_mem_wstrb,
    output cpu_mem_rdata, cpu_mem_ready,
    input  dbg_adr, dbg_wdata, dbg_rw, dbg_mem_op,
    output dbg_rdata, dbg_mem_rdy
  );
endinterface

// File: rtl/mem_bram32.sv
// rtl/mem_bram32.sv - single-port 32-bit RAM, byte write enables, 1-cycle registered read
module mem_bram32 #(
  parameter int WORDS = 2048
) (
  input  logic                     clk,
  input  logic                     en,
  input  logic [3:0]               we,
  input  logic [$clog2(WORDS)-1:0] addr,
  input  logic [31:0]              wdata,
  output logic [31:0]              rdata
);
  logic [31:0] mem [WORDS];

  // Read-before-write on the same port keeps the BRAM inference simple.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int b = 0; b < 4; b++) begin
        if (we[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
      rdata <= mem[addr];
    end
  end
endmodule

// File: rtl/mem_arb32.sv
// rtl/mem_arb32.sv - CPU/debug arbiter onto one single-port RAM (IDLE/ISSUE/ACK)
// Optional range check: define MEM_ARB_BOUNDS_EN.
module mem_arb32
  import mem_arb_pkg::*;
#(
  parameter int RAM_WORDS = RAM_WORDS_DEF
) (
  input  logic       clk,
  input  logic       n_reset,
  mem_arb32_if.slave bus,
  output logic       bounds_err
);
  localparam int AW = $clog2(RAM_WORDS);

  arb_state_t    state, state_nxt;
  logic          last_grant, win, lat_oob;
  logic [AW-1:0] lat_idx;
  logic [31:0]   lat_wdata;
  logic [3:0]    lat_strb;
  logic          req_cpu, req_dbg, req_any, grant_dbg, req_oob;
  logic [31:0]   req_addr;
  logic          ram_en;
  logic [3:0]    ram_we;
  logic [31:0]   ram_rdata, ack_rdata;
  logic          unused_addr;

  assign req_cpu   = bus.cpu_mem_valid;
  assign req_dbg   = bus.dbg_mem_op;
  assign req_any   = req_cpu | req_dbg;
  // Debug wins a tie unless it had the previous grant.
  assign grant_dbg = req_dbg && !(req_cpu && last_grant == MID_DBG);
  assign req_addr  = grant_dbg ? bus.dbg_adr : bus.cpu_mem_addr;

`ifdef MEM_ARB_BOUNDS_EN
  assign req_oob     = |req_addr[31:AW+2];
  assign unused_addr = ^req_addr[1:0];
`else
  assign req_oob     = 1'b0;
  assign unused_addr = ^{req_addr[31:AW+2], req_addr[1:0]};
`endif

  always_ff @(posedge clk) begin
    if (!n_reset) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (req_any) state_nxt = ST_ISSUE;
      ST_ISSUE: state_nxt = ST_ACK;
      ST_ACK:   state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      last_grant <= MID_CPU;
      win        <= MID_CPU;
      lat_idx    <= '0;
      lat_wdata  <= '0;
      lat_strb   <= '0;
      lat_oob    <= 1'b0;
    end else if (state == ST_IDLE && req_any) begin
      win        <= grant_dbg ? MID_DBG : MID_CPU;
      last_grant <= grant_dbg ? MID_DBG : MID_CPU;
      lat_idx    <= req_addr[AW+1:2];
      lat_wdata  <= grant_dbg ? bus.dbg_wdata : bus.cpu_mem_wdata;
      lat_strb   <= grant_dbg ? (bus.dbg_rw ? 4'h0 : STRB_FULL) : bus.cpu_mem_wstrb;
      lat_oob    <= req_oob;
    end
  end

`ifdef MEM_ARB_BOUNDS_EN
  always_ff @(posedge clk) begin
    if (!n_reset)                       bounds_err <= 1'b0;
    else if (state == ST_ISSUE && lat_oob) bounds_err <= 1'b1;
  end
`else
  assign bounds_err = 1'b0;
`endif

  // Outputs are gated by n_reset so a reset landing in ISSUE/ACK neither writes nor acks.
  always_comb begin
    ram_en            = 1'b0;
    ram_we            = 4'h0;
    ack_rdata         = lat_oob ? 32'h0 : ram_rdata;
    bus.cpu_mem_ready = 1'b0;
    bus.cpu_mem_rdata = 32'h0;
    bus.dbg_mem_rdy   = 1'b0;
    bus.dbg_rdata     = 32'h0;
    if (n_reset) begin
      if (state == ST_ISSUE && !lat_oob) begin
        ram_en = 1'b1;
        ram_we = lat_strb;
      end
      if (state == ST_ACK) begin
        if (win == MID_DBG) begin
          bus.dbg_mem_rdy = 1'b1;
          bus.dbg_rdata   = ack_rdata;
        end else begin
          bus.cpu_mem_ready = 1'b1;
          bus.cpu_mem_rdata = ack_rdata;
        end
      end
    end
  end

  mem_bram32 #(.WORDS(RAM_WORDS)) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (lat_idx),
    .wdata (lat_wdata),
    .rdata (ram_rdata)
  );
endmodule
